imuldiv_three_mul_resp_ser: RTL and testbench
=============================================

// Module: imuldiv_three_mul_resp_ser
// PURPOSE
//  Downstream stage of the three-input multiplier. Accepts one 96-bit signed product per
//  val/rdy transaction and re-emits it on a 32-bit response channel toward writeback.
//  Per-message mode selects the output: full 3-beat serialization, the low word only,
//  or the product saturated to signed 32 bits. A one-entry message buffer feeds a beat
//  counter, with overlap so back-to-back products stream without bubbles.
// PARAMETERS
//  BEAT_W   32  width of one output beat; fixed at 32, with the input equal to N_BEATS*BEAT_W
//  N_BEATS  3   beats per FULL-mode message
// PORTS
//  clk              in   1   clock
//  reset            in   1   synchronous active-high reset
//  in_msg_result    in   96  signed product from imuldiv_IntMulThreeInput
//  in_msg_mode      in   2   00 FULL, 01 LO, 10 SAT, 11 reserved (behaves as LO)
//  in_val           in   1   input message valid
//  in_rdy           out  1   input ready
//  out_msg_data     out  32  output beat
//  out_msg_last     out  1   final beat of the current message
//  out_msg_sat      out  1   SAT mode only: value was clamped; 0 in other modes
//  out_val          out  1   output beat valid
//  out_rdy          in   1   downstream ready
// BEHAVIOUR
//  - Clock is clk. Reset is synchronous and active-high on reset.
//  - Reset values: out_val=0, out_msg_data=0, out_msg_last=0, out_msg_sat=0, and
//    in_rdy=1 from the first cycle after reset.
//  - Reset mid-message discards the buffered message and the remaining beats. There is
//    no partial output after reset.
//  - States:
//    - S_EMPTY: no message held. in_rdy=1, out_val=0.
//    - S_SEND: message held; beat counter bidx runs 0..nb-1. out_val=1.
//  - Transitions:
//    - S_EMPTY -> S_SEND on in_val&&in_rdy. Latch the result and mode, set bidx=0.
//    - S_SEND stays in S_SEND on a non-last out transfer, with bidx++.
//    - On a last-beat transfer: go to S_SEND with a fresh bidx=0 if in_val is also high,
//      otherwise go to S_EMPTY.
//  - in_rdy = (state==S_EMPTY) || (out_val && out_rdy && out_msg_last). This is a
//    combinational path from out_rdy. Accepting a new message on the last-beat cycle is
//    required.
//  - Latency: the first beat appears with out_val=1 in the cycle after acceptance; no
//    combinational in->out path.
//  - Beats per message (nb):
//    - FULL: nb=3. Beat k carries result[32k+31:32k], low word first. last=1 on k=2.
//    - LO / 11: nb=1. data = result[31:0], last=1, sat=0.
//    - SAT: nb=1, last=1.
//      - If result > 2^31-1: data=32'h7FFFFFFF, sat=1.
//      - If result < -2^31: data=32'h80000000, sat=1.
//      - Otherwise: data=result[31:0], sat=0.
//      - Compare the full signed 96-bit value. In range means bits [95:31] are all equal.
//  - Backpressure: while out_val && !out_rdy, out_msg_data, out_msg_last, out_msg_sat and
//    bidx hold stable, and in_rdy=0.
//  - out_val never drops without a transfer, except on reset.
//  - Output fields are driven from registered state and a mux on bidx. SAT is computed
//    on the latched value, not the input.
// STRUCTURE
//  - Shared include imuldiv-ThreeMulRespMsg.v holds:
//    - mode encodings: MODE_FULL, MODE_LO, MODE_SAT
//    - field widths: RESULT_W=96, BEAT_W=32
//    - state encodings: S_EMPTY, S_SEND
//  - One natural sub-module: imuldiv_sat96to32. It is purely combinational: signed 96-bit
//    in -> {clamped 32-bit value, sat flag}. Instantiated once on the latched result.
//  - The top level holds the FSM, the message register, bidx and the beat mux.
// TESTING
//  1. FULL, result=96'hFFFFFFFF_FFFFFFFF_FFFFFFFA (-6), out_rdy=1 -> beats FFFFFFFA,
//     FFFFFFFF, FFFFFFFF on cycles +1,+2,+3; last only on the third; sat=0 throughout.
//  2. SAT, result=2^32 (96'h0_00000001_00000000) -> one beat 7FFFFFFF, sat=1, last=1.
//     SAT, result=-2^40 -> one beat 80000000, sat=1.
//  3. SAT, result=-5 -> FFFFFFFB, sat=0. SAT, result=2^31-1 -> 7FFFFFFF, sat=0
//     (boundary, not clamped). LO, result=96'h12345678_9ABCDEF0_0BADF00D -> 0BADF00D, sat=0.
//  4. FULL, out_rdy low for 4 cycles during beat 1 -> data and last stay stable, in_rdy=0
//     throughout, and beat 2 follows 1 cycle after out_rdy rises.
//  5. Two FULL messages with in_val held high and out_rdy=1 -> the second is accepted on
//     the cycle the first's last beat transfers; 6 beats on 6 consecutive cycles with no
//     bubble.
//  6. reset asserted for 1 cycle during beat 1 of FULL -> next cycle out_val=0 and
//     in_rdy=1; no remaining beats; a new LO message is then processed normally.

Source files
------------

// File: rtl/imuldiv_three_mul_resp_ser_pkg.sv
// Shared encodings and widths for the three-input multiplier response serializer.
package imuldiv_three_mul_resp_ser_pkg;

  // One output beat is a 32-bit word; a full product spans three beats.
  localparam int BEAT_W   = 32;
  localparam int N_BEATS  = 3;
  localparam int RESULT_W = N_BEATS * BEAT_W;

  // Per-message output mode. The reserved code is treated like MODE_LO.
  typedef enum logic [1:0] {
    MODE_FULL = 2'b00,
    MODE_LO   = 2'b01,
    MODE_SAT  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // Message-holding FSM states.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_SEND  = 1'b1
  } state_e;

  // Index of the final beat of a message in the given mode.
  function automatic logic [1:0] last_bidx(input mode_e mode);
    return (mode == MODE_FULL) ? 2'(N_BEATS - 1) : 2'd0;
  endfunction

endpackage

// File: rtl/imuldiv_sat96to32.sv
// Purely combinational clamp of a signed 96-bit value to the signed 32-bit range.
module imuldiv_sat96to32
  import imuldiv_three_mul_resp_ser_pkg::*;
(
  input  logic [RESULT_W-1:0] in_result,
  output logic [BEAT_W-1:0]   out_value,
  output logic                out_sat
);

  // The value fits in 32 signed bits exactly when bits [95:31] are all equal.
  logic in_range;
  assign in_range = (&in_result[RESULT_W-1:BEAT_W-1]) || (~|in_result[RESULT_W-1:BEAT_W-1]);

  // Pass the low word through when in range, otherwise clamp toward the sign.
  always_comb begin
    out_value = in_result[BEAT_W-1:0];
    out_sat   = 1'b0;
    if (!in_range) begin
      out_sat   = 1'b1;
      out_value = in_result[RESULT_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

endmodule

// File: rtl/imuldiv_three_mul_resp_ser.sv
// Response serializer: buffers one 96-bit product and emits it as 32-bit beats
// (full 3-beat, low word only, or saturated), streaming back-to-back messages.
module imuldiv_three_mul_resp_ser
  import imuldiv_three_mul_resp_ser_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [RESULT_W-1:0] in_msg_result,
  input  logic [1:0]          in_msg_mode,
  input  logic                in_val,
  output logic                in_rdy,
  output logic [BEAT_W-1:0]   out_msg_data,
  output logic                out_msg_last,
  output logic                out_msg_sat,
  output logic                out_val,
  input  logic                out_rdy
);

  state_e              state_reg, state_next;
  logic [RESULT_W-1:0] result_reg, result_next;
  mode_e               mode_reg, mode_next;
  logic [1:0]          bidx_reg, bidx_next;

  logic [BEAT_W-1:0]   beat_word [N_BEATS];
  logic [BEAT_W-1:0]   sat_value;
  logic                sat_flag;
  logic                beat_last;
  logic                xfer_last;
  logic                accept;

  // Split the held product into its beat words, low word first.
  generate
    for (genvar gi = 0; gi < N_BEATS; gi++) begin : g_beat
      assign beat_word[gi] = result_reg[gi*BEAT_W +: BEAT_W];
    end
  endgenerate

  // Saturation works on the latched product, never on the live input.
  imuldiv_sat96to32 u_sat (
    .in_result (result_reg),
    .out_value (sat_value),
    .out_sat   (sat_flag)
  );

  assign out_val      = (state_reg == S_SEND);
  assign beat_last    = (bidx_reg == last_bidx(mode_reg));
  assign out_msg_last = out_val && beat_last;
  assign out_msg_sat  = out_val && (mode_reg == MODE_SAT) && sat_flag;

  // A new message can enter while idle or on the cycle the last beat leaves,
  // which is what lets consecutive products stream without a bubble.
  assign xfer_last = out_val && out_rdy && beat_last;
  assign in_rdy    = (state_reg == S_EMPTY) || xfer_last;
  assign accept    = in_val && in_rdy;

  // Beat mux: select the output word from the held message and beat index.
  always_comb begin
    out_msg_data = '0;
    if (out_val) begin
      case (mode_reg)
        MODE_FULL: begin
          case (bidx_reg)
            2'd0:    out_msg_data = beat_word[0];
            2'd1:    out_msg_data = beat_word[1];
            default: out_msg_data = beat_word[2];
          endcase
        end
        MODE_SAT: out_msg_data = sat_value;
        default:  out_msg_data = beat_word[0];
      endcase
    end
  end

  // Next-state logic: latch on acceptance, advance bidx on each beat transfer.
  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    mode_next   = mode_reg;
    bidx_next   = bidx_reg;
    case (state_reg)
      S_EMPTY: begin
        if (accept) begin
          state_next  = S_SEND;
          result_next = in_msg_result;
          mode_next   = mode_e'(in_msg_mode);
          bidx_next   = 2'd0;
        end
      end
      S_SEND: begin
        if (out_rdy) begin
          if (beat_last) begin
            if (accept) begin
              state_next  = S_SEND;
              result_next = in_msg_result;
              mode_next   = mode_e'(in_msg_mode);
              bidx_next   = 2'd0;
            end else begin
              state_next = S_EMPTY;
              bidx_next  = 2'd0;
            end
          end else begin
            bidx_next = bidx_reg + 2'd1;
          end
        end
      end
      default: begin
        state_next = S_EMPTY;
        bidx_next  = 2'd0;
      end
    endcase
  end

  // State, message and beat-index registers; reset drops any held message.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_EMPTY;
      result_reg <= '0;
      mode_reg   <= MODE_FULL;
      bidx_reg   <= 2'd0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      mode_reg   <= mode_next;
      bidx_reg   <= bidx_next;
    end
  end

endmodule

// File: tb/tb_imuldiv_three_mul_resp_ser.sv
// Self-checking bench: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the expected output beats.
module tb_imuldiv_three_mul_resp_ser;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [95:0] in_msg_result = '0;
  logic [1:0]  in_msg_mode = 2'b00;
  logic        in_val = 1'b0;
  logic        in_rdy;
  logic [31:0] out_msg_data;
  logic        out_msg_last;
  logic        out_msg_sat;
  logic        out_val;
  logic        out_rdy = 1'b1;

  int checks = 0;
  int failures = 0;
  bit rdy_random = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        sat;
  } beat_t;

  beat_t exp_q[$];

  imuldiv_three_mul_resp_ser dut (
    .clk           (clk),
    .reset         (reset),
    .in_msg_result (in_msg_result),
    .in_msg_mode   (in_msg_mode),
    .in_val        (in_val),
    .in_rdy        (in_rdy),
    .out_msg_data  (out_msg_data),
    .out_msg_last  (out_msg_last),
    .out_msg_sat   (out_msg_sat),
    .out_val       (out_val),
    .out_rdy       (out_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the beats a message must produce, from the mode rules.
  function automatic void model_push(input logic [95:0] r, input logic [1:0] m);
    beat_t b;
    logic signed [95:0] v;
    logic signed [95:0] hi;
    logic signed [95:0] lo;
    v  = $signed(r);
    hi = 96'sh7FFF_FFFF;
    lo = -96'sh8000_0000;
    if (m == 2'b00) begin
      for (int k = 0; k < 3; k++) begin
        b.data = r[32*k +: 32];
        b.last = (k == 2);
        b.sat  = 1'b0;
        exp_q.push_back(b);
      end
    end else if (m == 2'b10) begin
      b.last = 1'b1;
      if (v > hi) begin
        b.data = 32'h7FFF_FFFF;
        b.sat  = 1'b1;
      end else if (v < lo) begin
        b.data = 32'h8000_0000;
        b.sat  = 1'b1;
      end else begin
        b.data = r[31:0];
        b.sat  = 1'b0;
      end
      exp_q.push_back(b);
    end else begin
      b.data = r[31:0];
      b.last = 1'b1;
      b.sat  = 1'b0;
      exp_q.push_back(b);
    end
  endfunction

  // Scoreboard: every cycle compare handshake and beat fields with the model.
  always @(negedge clk) begin : monitor
    logic exp_rdy;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() == 0) exp_rdy = 1'b1;
      else                   exp_rdy = out_rdy && exp_q[0].last;
      check("in_rdy", {95'd0, in_rdy}, {95'd0, exp_rdy});
      check("out_val", {95'd0, out_val}, {95'd0, exp_q.size() != 0});
      if (out_val && exp_q.size() != 0) begin
        check("data", {64'd0, out_msg_data}, {64'd0, exp_q[0].data});
        check("last", {95'd0, out_msg_last}, {95'd0, exp_q[0].last});
        check("sat", {95'd0, out_msg_sat}, {95'd0, exp_q[0].sat});
        if (out_rdy) begin
          $display("beat data=%h last=%b sat=%b", out_msg_data, out_msg_last, out_msg_sat);
          void'(exp_q.pop_front());
        end
      end
      if (in_val && in_rdy) model_push(in_msg_result, in_msg_mode);
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_random) out_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // Offer one message and wait (bounded) for it to be accepted.
  task automatic send(input logic [95:0] r, input logic [1:0] m, input bit keep_val);
    bit got;
    got = 1'b0;
    in_msg_result = r;
    in_msg_mode   = m;
    in_val        = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_rdy) got = 1'b1;
    end
    if (!got) check("accept_timeout", 96'd0, 96'd1);
    @(posedge clk);
    #1;
    if (!keep_val) in_val = 1'b0;
  endtask

  // Wait (bounded) until every expected beat has been seen.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 96'd0, 96'd1);
  endtask

  function automatic logic [95:0] rand_result();
    logic [31:0] w;
    logic [63:0] x;
    logic signed [95:0] d;
    case ($urandom_range(0, 3))
      0: rand_result = {$urandom, $urandom, $urandom};
      1: begin
        w = $urandom;
        rand_result = {{64{w[31]}}, w};
      end
      2: begin
        x = {$urandom, $urandom};
        rand_result = {{32{x[63]}}, x};
      end
      default: begin
        d = $signed(96'($urandom_range(0, 4))) - 96'sd2;
        if ($urandom_range(0, 1) == 1) rand_result = 96'sh7FFF_FFFF + d;
        else                           rand_result = -96'sh8000_0000 + d;
      end
    endcase
  endfunction

  initial begin : stim
    int gap;
    int next_gap;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_val", {95'd0, out_val}, 96'd0);
    check("rst_in_rdy", {95'd0, in_rdy}, 96'd1);
    check("rst_data", {64'd0, out_msg_data}, 96'd0);
    check("rst_last", {95'd0, out_msg_last}, 96'd0);
    check("rst_sat", {95'd0, out_msg_sat}, 96'd0);
    @(posedge clk);
    #1;

    // FULL of -6
    send(96'hFFFFFFFF_FFFFFFFF_FFFFFFFA, 2'b00, 1'b0);
    drain();
    // SAT clamps high and low
    send(96'h00000000_00000001_00000000, 2'b10, 1'b0);
    send(96'hFFFFFFFF_FFFFFF00_00000000, 2'b10, 1'b0);
    drain();
    // SAT in range, SAT boundary, LO, reserved mode
    send(96'hFFFFFFFF_FFFFFFFF_FFFFFFFB, 2'b10, 1'b0);
    send(96'h00000000_00000000_7FFFFFFF, 2'b10, 1'b0);
    send(96'hFFFFFFFF_FFFFFFFF_80000000, 2'b10, 1'b0);
    send(96'h12345678_9ABCDEF0_0BADF00D, 2'b01, 1'b0);
    send(96'h12345678_9ABCDEF0_0BADF00D, 2'b11, 1'b0);
    drain();

    // Backpressure on beat 1 for 4 cycles
    send(96'hAAAA5555_12345678_DEADBEEF, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    out_rdy = 1'b1;
    drain();

    // Two FULL messages back to back
    send(96'h33333333_22222222_11111111, 2'b00, 1'b1);
    send(96'h66666666_55555555_44444444, 2'b00, 1'b0);
    drain();

    // Reset during beat 1, then a normal LO message
    send(96'h99999999_88888888_77777777, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out_val", {95'd0, out_val}, 96'd0);
    check("mid_rst_in_rdy", {95'd0, in_rdy}, 96'd1);
    @(posedge clk);
    #1;
    send(96'h00000000_00000000_CAFEF00D, 2'b01, 1'b0);
    drain();

    // Randomized traffic with random gaps and backpressure
    rdy_random = 1'b1;
    next_gap = $urandom_range(0, 2);
    for (int i = 0; i < 120; i++) begin
      gap = next_gap;
      next_gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      send(rand_result(), 2'($urandom_range(0, 3)), next_gap == 0);
    end
    in_val = 1'b0;
    rdy_random = 1'b0;
    @(posedge clk);
    #2;
    out_rdy = 1'b1;
    drain();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
